// File: rtl/seg7_scan_display_if.sv
// Display-side bundle for seg7_scan_display: load/blank controls in, scanned segment and enable pins out.
// The master side belongs to the producer of the values, and the slave side belongs to the driver.
interface seg7_scan_display_if #(
   parameter int NUM_DIGITS = 8
);
   logic                      Load;
   logic [4*NUM_DIGITS-1:0]   Value;
   logic [NUM_DIGITS-1:0]     DpMask;
   logic                      Blank;
   logic [6:0]                out7;
   logic                      dp_out;
   logic [NUM_DIGITS-1:0]     en_out;
   logic                      FrameDone;

   modport master (
      output Load, Value, DpMask, Blank,
      input  out7, dp_out, en_out, FrameDone
   );

   modport slave (
      input  Load, Value, DpMask, Blank,
      output out7, dp_out, en_out, FrameDone
   );
endinterface

// File: rtl/seg7_scan_display.sv
// Multiplexed hex seven-segment driver: clock-enable scan, double-buffered values committed at frame wrap,
// leading-zero blanking, per-digit decimal points, global blank. Outputs are registered one cycle after the index.
module seg7_scan_display #(
   parameter int NUM_DIGITS  = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   seg7_scan_display_if.slave   bus
);
   localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int VW = 4 * NUM_DIGITS;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]          r_cnt;
   logic [IW-1:0]          r_idx;
   logic [VW-1:0]          r_sh_val;
   logic [NUM_DIGITS-1:0]  r_sh_dp;
   logic                   r_pend;
   logic [VW-1:0]          r_act_val;
   logic [NUM_DIGITS-1:0]  r_act_dp;
   logic [6:0]             r_out7;
   logic                   r_dp;
   logic [NUM_DIGITS-1:0]  r_en;
   logic                   r_fd;

   logic                   w_tick;
   logic                   w_wrap;
   logic [3:0]             w_nib;
   logic                   w_dp_bit;
   logic                   w_upper_nz;
   logic                   w_off;
   logic [NUM_DIGITS-1:0]  w_en_nxt;
   logic [6:0]             w_seg;

   assign w_tick = (r_cnt == CNT_MAX);
   assign w_wrap = w_tick && (r_idx == IDX_MAX);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         r_idx <= w_wrap ? '0 : r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A Load landing on the wrapping tick bypasses the shadow and commits directly.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_sh_val  <= '0;
         r_sh_dp   <= '0;
         r_pend    <= 1'b0;
         r_act_val <= '0;
         r_act_dp  <= '0;
      end else if (w_wrap) begin
         r_pend <= 1'b0;
         if (bus.Load) begin
            r_act_val <= bus.Value;
            r_act_dp  <= bus.DpMask;
         end else if (r_pend) begin
            r_act_val <= r_sh_val;
            r_act_dp  <= r_sh_dp;
         end
      end else if (bus.Load) begin
         r_sh_val <= bus.Value;
         r_sh_dp  <= bus.DpMask;
         r_pend   <= 1'b1;
      end
   end

   // A digit stays lit if any nibble or decimal point at or above it is non-zero.
   always_comb begin
      w_nib      = 4'h0;
      w_dp_bit   = 1'b0;
      w_upper_nz = 1'b0;
      w_en_nxt   = '1;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (r_idx == IW'(j)) begin
            w_nib    = r_act_val[4*j +: 4];
            w_dp_bit = r_act_dp[j];
         end
         if (IW'(j) >= r_idx) begin
            w_upper_nz = w_upper_nz | (r_act_val[4*j +: 4] != 4'h0) | r_act_dp[j];
         end
      end
      w_off = bus.Blank || ((BLANK_LZ != 0) && (r_idx != '0) && !w_upper_nz);
      for (int j = 0; j < NUM_DIGITS; j++) begin
         w_en_nxt[j] = w_off || (r_idx != IW'(j));
      end
   end

   always_comb begin
      w_seg = 7'h7F;
      case (w_nib)
         4'h0: w_seg = 7'b1000000;
         4'h1: w_seg = 7'b1111001;
         4'h2: w_seg = 7'b0100100;
         4'h3: w_seg = 7'b0110000;
         4'h4: w_seg = 7'b0011001;
         4'h5: w_seg = 7'b0010010;
         4'h6: w_seg = 7'b0000010;
         4'h7: w_seg = 7'b1111000;
         4'h8: w_seg = 7'b0000000;
         4'h9: w_seg = 7'b0010000;
         4'hA: w_seg = 7'b0001000;
         4'hB: w_seg = 7'b0000011;
         4'hC: w_seg = 7'b1000110;
         4'hD: w_seg = 7'b0100001;
         4'hE: w_seg = 7'b0000110;
         4'hF: w_seg = 7'b0001110;
         default: w_seg = 7'h7F;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_out7 <= 7'h7F;
         r_dp   <= 1'b1;
         r_en   <= '1;
         r_fd   <= 1'b0;
      end else begin
         r_out7 <= w_off ? 7'h7F : w_seg;
         r_dp   <= w_off | ~w_dp_bit;
         r_en   <= w_en_nxt;
         r_fd   <= w_wrap;
      end
   end

   assign bus.out7      = r_out7;
   assign bus.dp_out    = r_dp;
   assign bus.en_out    = r_en;
   assign bus.FrameDone = r_fd;
endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display (4 digits, hold 4): frame-arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized load/blank phase.
module tb_seg7_scan_display;
   localparam int N   = 4;
   localparam int DIV = 4;
   localparam int LZ  = 1;
   localparam int F   = N * DIV;

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   seg7_scan_display_if #(.NUM_DIGITS(N)) bus ();

   seg7_scan_display #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(DIV),
      .BLANK_LZ   (LZ)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus.slave)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: p counts Clk edges since reset release; frames wrap every F edges.
   int          p = 0;
   logic [15:0] m_act_v, m_sh_v;
   logic [3:0]  m_act_dp, m_sh_dp;
   bit          m_pend;

   always begin : monitor
      int          idx;
      bit          off;
      logic [6:0]  e_o7;
      logic        e_dp;
      logic [3:0]  e_en;
      logic        e_fd;
      @(posedge Clk);
      if (Reset) begin
         p = 0; m_act_v = '0; m_act_dp = '0; m_sh_v = '0; m_sh_dp = '0; m_pend = 0;
      end else begin
         idx  = (p / DIV) % N;
         off  = bus.Blank ||
                (LZ != 0 && idx > 0 && (m_act_v >> (4*idx)) == 0 && (m_act_dp >> idx) == 0);
         e_en = off ? 4'hF : ~(4'b0001 << idx);
         e_o7 = off ? 7'h7F : seg_tab[(m_act_v >> (4*idx)) & 16'hF];
         e_dp = off ? 1'b1 : ~m_act_dp[idx];
         e_fd = ((p + 1) % F == 0);
         if ((p + 1) % F == 0) begin
            if (bus.Load) begin
               m_act_v = bus.Value; m_act_dp = bus.DpMask;
            end else if (m_pend) begin
               m_act_v = m_sh_v; m_act_dp = m_sh_dp;
            end
            m_pend = 0;
         end else if (bus.Load) begin
            m_sh_v = bus.Value; m_sh_dp = bus.DpMask; m_pend = 1;
         end
         p++;
         #1;
         chk("model_out7",   bus.out7,      e_o7);
         chk("model_dp",     bus.dp_out,    e_dp);
         chk("model_en",     bus.en_out,    e_en);
         chk("model_frame",  bus.FrameDone, e_fd);
      end
   end

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      bus.Load = 1'b1; bus.Value = v; bus.DpMask = dp;
      @(negedge Clk);
      bus.Load = 1'b0;
   endtask

   task automatic wait_fd(input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < 4*F && !seen; i++) begin
         @(negedge Clk);
         if (bus.FrameDone === 1'b1) seen = 1;
      end
      if (!seen) chk({nm, "_timeout"}, 0, 1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_out7"}, bus.out7, 7'h7F);
      chk({nm, "_dp"},   bus.dp_out, 1'b1);
      chk({nm, "_en"},   bus.en_out, 4'hF);
      chk({nm, "_fd"},   bus.FrameDone, 1'b0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : driver
      int n;
      logic [15:0] v;
      bus.Load = 1'b0; bus.Value = '0; bus.DpMask = '0; bus.Blank = 1'b0;
      repeat (3) @(negedge Clk);
      chk_reset_vals("reset");
      Reset = 1'b0;

      // Scan order and decode of 12AF
      do_load(16'h12AF, 4'b0000);
      wait_fd("t1_fd");
      @(negedge Clk);
      chk("t1_d0_en",   bus.en_out, 4'b1110);
      chk("t1_d0_out7", bus.out7,   7'b0001110);
      repeat (DIV) @(negedge Clk);
      chk("t1_d1_en",   bus.en_out, 4'b1101);
      repeat (2*DIV) @(negedge Clk);
      chk("t1_d3_en",   bus.en_out, 4'b0111);
      chk("t1_d3_out7", bus.out7,   7'b1111001);
      wait_fd("t1_fd2");
      n = 0;
      do begin @(negedge Clk); n++; end while (bus.FrameDone !== 1'b1 && n < 4*F);
      chk("t1_frame_period", n, F);

      // Mid-frame load is held until the wrap
      repeat (5) @(negedge Clk);
      do_load(16'h00A0, 4'b0000);
      repeat (7) @(negedge Clk);
      chk("t2_old_d3", bus.out7, 7'b1111001);
      wait_fd("t2_fd");
      @(negedge Clk);
      chk("t2_d0", bus.out7, 7'b1000000);
      repeat (DIV) @(negedge Clk);
      chk("t2_d1", bus.out7, 7'b0001000);
      repeat (DIV) @(negedge Clk);
      chk("t2_d2_en",   bus.en_out, 4'hF);
      chk("t2_d2_out7", bus.out7,   7'h7F);
      repeat (DIV) @(negedge Clk);
      chk("t2_d3_en", bus.en_out, 4'hF);

      // Latest load wins, including one on the wrapping tick
      wait_fd("t3_fd");
      do_load(16'h1111, 4'b0000);
      repeat (2) @(negedge Clk);
      do_load(16'h2222, 4'b0000);
      n = 0;
      while (p % F != F - 1 && n < 2*F) begin @(negedge Clk); n++; end
      do_load(16'h3333, 4'b0000);
      @(negedge Clk);
      chk("t3_d0", bus.out7, 7'b0110000);
      repeat (3*DIV) @(negedge Clk);
      chk("t3_d3", bus.out7, 7'b0110000);

      // Decimal point overrides leading-zero blanking
      do_load(16'h0000, 4'b0100);
      wait_fd("t4_fd");
      @(negedge Clk);
      chk("t4_d0_out7", bus.out7, 7'b1000000);
      chk("t4_d0_dp",   bus.dp_out, 1'b1);
      repeat (2*DIV) @(negedge Clk);
      chk("t4_d2_dp",   bus.dp_out, 1'b0);
      chk("t4_d2_en",   bus.en_out, 4'b1011);
      repeat (DIV) @(negedge Clk);
      chk("t4_d3_en",   bus.en_out, 4'hF);

      // Global blank
      bus.Blank = 1'b1;
      @(negedge Clk);
      chk("t5_blank_en", bus.en_out, 4'hF);
      repeat (9) @(negedge Clk);
      bus.Blank = 1'b0;
      @(negedge Clk);
      chk("t5_unblank", bus.en_out == 4'hF, 1'b0);

      // Randomized loads and blanking
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 7) == 0 || (p % F == F - 1 && $urandom_range(0, 1) == 0)) begin
            v = 16'($urandom) >> $urandom_range(0, 16);
            bus.Load   = 1'b1;
            bus.Value  = v;
            bus.DpMask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         end else begin
            bus.Load = 1'b0;
         end
         if ($urandom_range(0, 15) == 0) bus.Blank = ~bus.Blank;
         @(negedge Clk);
      end
      bus.Load = 1'b0; bus.Blank = 1'b0;

      // Asynchronous reset with a load pending
      wait_fd("t6_fd");
      do_load(16'h5678, 4'b0000);
      @(posedge Clk);
      #2 Reset = 1'b1;
      #1 chk_reset_vals("t6_async");
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      chk("t6_d0_out7", bus.out7,   7'b1000000);
      chk("t6_d0_en",   bus.en_out, 4'b1110);
      n = 1;
      while (bus.FrameDone !== 1'b1 && n < 4*F) begin @(negedge Clk); n++; end
      chk("t6_first_frame", n, F);
      @(negedge Clk);
      chk("t6_pending_lost", bus.out7, 7'b1000000);
      repeat (2*F) @(negedge Clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
